// File: rtl/tc_tile_sched.sv
// Tile scheduler: walks the GEMM tile space m->k->n (n innermost), one descriptor per handshake.
// A fixed-latency tag pipeline reports each output tile once its last k-step leaves the array.
module tc_tile_sched #(
  parameter int unsigned M      = 16,
  parameter int unsigned K      = 16,
  parameter int unsigned N      = 16,
  parameter int unsigned M_TILE = 4,
  parameter int unsigned K_TILE = 4,
  parameter int unsigned N_TILE = 4,
  parameter int unsigned DW_INT = 32,
  parameter int unsigned LAT    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              issue_ready,
  output logic              issue_valid,
  output logic              issue_load_a,
  output logic              issue_first_k,
  output logic              issue_last_k,
  output logic [DW_INT-1:0] ptr_m,
  output logic [DW_INT-1:0] ptr_k,
  output logic [DW_INT-1:0] ptr_n,
  output logic              retire_valid,
  output logic [DW_INT-1:0] retire_m,
  output logic [DW_INT-1:0] retire_n,
  output logic              busy,
  output logic              done
);
  localparam int unsigned ITER_M = (M + M_TILE - 1) / M_TILE;
  localparam int unsigned ITER_K = (K + K_TILE - 1) / K_TILE;
  localparam int unsigned ITER_N = (N + N_TILE - 1) / N_TILE;
  localparam logic [DW_INT-1:0] LAST_M = DW_INT'(ITER_M - 1);
  localparam logic [DW_INT-1:0] LAST_K = DW_INT'(ITER_K - 1);
  localparam logic [DW_INT-1:0] LAST_N = DW_INT'(ITER_N - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;
  state_e state_q;

  logic              tag_vld_q [LAT];
  logic [DW_INT-1:0] tag_m_q   [LAT];
  logic [DW_INT-1:0] tag_n_q   [LAT];

  logic xfer;
  logic push;
  logic drain_empty;

  // Flags are gated by issue_valid so every output reads 0 out of reset.
  assign issue_load_a  = issue_valid && (ptr_n == '0);
  assign issue_first_k = issue_valid && (ptr_k == '0);
  assign issue_last_k  = issue_valid && (ptr_k == LAST_K);

  assign xfer = issue_valid && issue_ready;
  assign push = xfer && issue_last_k;

  assign retire_valid = tag_vld_q[LAT-1];
  assign retire_m     = tag_m_q[LAT-1];
  assign retire_n     = tag_n_q[LAT-1];

  // The last stage is the visible retire slot; once the earlier stages are empty, the
  // current retire (if any) is the final one and the next cycle is the done cycle.
  always_comb begin
    drain_empty = 1'b1;
    for (int i = 0; i < int'(LAT) - 1; i++) begin
      if (tag_vld_q[i]) drain_empty = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      issue_valid <= 1'b0;
      ptr_m       <= '0;
      ptr_k       <= '0;
      ptr_n       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < int'(LAT); i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_m_q[i]   <= '0;
        tag_n_q[i]   <= '0;
      end
    end else if (enable) begin
      done <= 1'b0;
      for (int i = int'(LAT) - 1; i > 0; i--) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_m_q[i]   <= tag_m_q[i-1];
        tag_n_q[i]   <= tag_n_q[i-1];
      end
      tag_vld_q[0] <= push;
      tag_m_q[0]   <= push ? ptr_m : '0;
      tag_n_q[0]   <= push ? ptr_n : '0;

      unique case (state_q)
        StIdle: begin
          // start coinciding with the done pulse is deliberately ignored
          if (start && !done) begin
            state_q     <= StIssue;
            issue_valid <= 1'b1;
            busy        <= 1'b1;
            ptr_m       <= '0;
            ptr_k       <= '0;
            ptr_n       <= '0;
          end
        end
        StIssue: begin
          if (xfer) begin
            if (ptr_n == LAST_N) begin
              ptr_n <= '0;
              if (ptr_k == LAST_K) begin
                ptr_k <= '0;
                if (ptr_m == LAST_M) begin
                  ptr_m       <= '0;
                  state_q     <= StDrain;
                  issue_valid <= 1'b0;
                end else begin
                  ptr_m <= ptr_m + 1'b1;
                end
              end else begin
                ptr_k <= ptr_k + 1'b1;
              end
            end else begin
              ptr_n <= ptr_n + 1'b1;
            end
          end
        end
        StDrain: begin
          if (drain_empty) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
